// File: rtl/fp_wb_arbiter.sv
// Dual-port round-robin writeback arbiter for FP functional units.
// Optional conflict counter enabled by FP_WB_ARB_PERF_EN.
module fp_wb_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3,
  parameter int DATA_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_UNITS-1:0]        unit_done,
  input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_rd,
  output logic [NUM_UNITS-1:0]        unit_ack,
  output logic [1:0]                  wb_valid,
  output logic [2*ID_W-1:0]           wb_id,
  output logic [2*DATA_W-1:0]         wb_data,
  output logic [15:0]                 perf_conflicts
);

  localparam int PTR_W = $clog2(NUM_UNITS);

  logic [PTR_W-1:0]  rr_q;
  logic [PTR_W-1:0]  rr_d;
  logic [PTR_W-1:0]  w0;
  logic [PTR_W-1:0]  w1;
  logic [PTR_W-1:0]  last;
  logic              has0;
  logic              has1;
  logic [1:0]        vld_q;
  logic [ID_W-1:0]   id0_q;
  logic [ID_W-1:0]   id1_q;
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;

  logic [ID_W-1:0]   id_a [NUM_UNITS];
  logic [DATA_W-1:0] rd_a [NUM_UNITS];

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
    assign id_a[g] = unit_id[g*ID_W +: ID_W];
    assign rd_a[g] = unit_rd[g*DATA_W +: DATA_W];
  end

  // Port 0: first requester at or after the round-robin pointer.
  always_comb begin
    int j;
    logic [PTR_W-1:0] idx;
    has0 = 1'b0;
    w0   = '0;
    j    = 0;
    idx  = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_UNITS) j = j - NUM_UNITS;
      idx = PTR_W'(j);
      if (!has0 && unit_done[idx]) begin
        has0 = 1'b1;
        w0   = idx;
      end
    end
  end

  // Port 1: next requester strictly after the port-0 winner.
  always_comb begin
    int j;
    logic [PTR_W-1:0] idx;
    has1 = 1'b0;
    w1   = '0;
    j    = 0;
    idx  = '0;
    for (int k = 1; k < NUM_UNITS; k++) begin
      j = int'(w0) + k;
      if (j >= NUM_UNITS) j = j - NUM_UNITS;
      idx = PTR_W'(j);
      if (has0 && !has1 && unit_done[idx]) begin
        has1 = 1'b1;
        w1   = idx;
      end
    end
  end

  always_comb begin
    unit_ack = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_ack[i] = rst &&
                    ((has0 && (w0 == PTR_W'(i))) ||
                     (has1 && (w1 == PTR_W'(i))));
    end
  end

  always_comb begin
    last = has1 ? w1 : w0;
    rr_d = rr_q;
    if (has0) begin
      if (int'(last) == NUM_UNITS - 1) rr_d = '0;
      else                             rr_d = last + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q  <= '0;
      vld_q <= 2'b00;
    end else begin
      rr_q  <= rr_d;
      vld_q <= {has1, has0};
    end
  end

  always_ff @(posedge clk) begin
    id0_q <= id_a[w0];
    id1_q <= id_a[w1];
    rd0_q <= rd_a[w0];
    rd1_q <= rd_a[w1];
  end

  // Reset hides a pending result immediately; the flush owns it.
  assign wb_valid = vld_q & {2{rst}};
  assign wb_id    = {id1_q, id0_q};
  assign wb_data  = {rd1_q, rd0_q};

`ifdef FP_WB_ARB_PERF_EN
  logic [3:0]  nreq;
  logic [15:0] perf_q;

  always_comb begin
    nreq = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      nreq = nreq + {3'b000, unit_done[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (nreq > 4'd2 && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_conflicts = perf_q;
`else
  assign perf_conflicts = 16'h0000;
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: vector table plus
// writeback scoreboard and conflict-counter saturation run.
module tb_fp_wb_arbiter;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int DW = 64;

  logic            clk;
  logic            rst;
  logic [N-1:0]    unit_done;
  logic [N*IW-1:0] unit_id;
  logic [N*DW-1:0] unit_rd;
  logic [N-1:0]    unit_ack;
  logic [1:0]      wb_valid;
  logic [2*IW-1:0] wb_id;
  logic [2*DW-1:0] wb_data;
  logic [15:0]     perf_conflicts;

  fp_wb_arbiter #(.NUM_UNITS(N), .ID_W(IW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .unit_done      (unit_done),
    .unit_id        (unit_id),
    .unit_rd        (unit_rd),
    .unit_ack       (unit_ack),
    .wb_valid       (wb_valid),
    .wb_id          (wb_id),
    .wb_data        (wb_data),
    .perf_conflicts (perf_conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] done;
    int         p0;
    int         p1;
  } row_t;

  typedef struct {
    logic [1:0]    v;
    logic [IW-1:0] id0;
    logic [IW-1:0] id1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } wb_t;

  row_t tbl [24];
  wb_t  sb [$];
  int   n_chk;
  int   n_fail;
  int   perf_m;

  function automatic logic [IW-1:0] uid(int u);
    return IW'((u + 3) % 8);
  endfunction

  function automatic logic [DW-1:0] urd(int u);
    return {16'hFACE, 16'(u), 32'hDEAD_0000 + 32'(u)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int popc(logic [3:0] d);
    return int'(d[0]) + int'(d[1]) + int'(d[2]) + int'(d[3]);
  endfunction

  initial begin
    wb_t        e;
    wb_t        x;
    logic [3:0] ea;
    string      tg;

    n_chk  = 0;
    n_fail = 0;
    perf_m = 0;

    tbl[0]  = '{1'b0, 4'b0000, -1, -1};
    tbl[1]  = '{1'b0, 4'b0100, -1, -1};
    tbl[2]  = '{1'b1, 4'b0100,  2, -1};
    tbl[3]  = '{1'b1, 4'b0000, -1, -1};
    tbl[4]  = '{1'b1, 4'b0001,  0, -1};
    tbl[5]  = '{1'b1, 4'b0011,  1,  0};
    tbl[6]  = '{1'b1, 4'b1111,  1,  2};
    tbl[7]  = '{1'b1, 4'b1111,  3,  0};
    tbl[8]  = '{1'b1, 4'b1010,  1,  3};
    tbl[9]  = '{1'b1, 4'b0110,  1,  2};
    tbl[10] = '{1'b1, 4'b1000,  3, -1};
    tbl[11] = '{1'b1, 4'b1001,  0,  3};
    tbl[12] = '{1'b1, 4'b1111,  0,  1};
    tbl[13] = '{1'b1, 4'b1111,  2,  3};
    tbl[14] = '{1'b1, 4'b1111,  0,  1};
    tbl[15] = '{1'b1, 4'b0100,  2, -1};
    tbl[16] = '{1'b1, 4'b0000, -1, -1};
    tbl[17] = '{1'b1, 4'b0100,  2, -1};
    tbl[18] = '{1'b1, 4'b0001,  0, -1};
    tbl[19] = '{1'b1, 4'b0010,  1, -1};
    tbl[20] = '{1'b0, 4'b1111, -1, -1};
    tbl[21] = '{1'b0, 4'b1111, -1, -1};
    tbl[22] = '{1'b1, 4'b1010,  1,  3};
    tbl[23] = '{1'b1, 4'b0000, -1, -1};

    for (int u = 0; u < N; u++) begin
      unit_id[u*IW +: IW] = uid(u);
      unit_rd[u*DW +: DW] = urd(u);
    end
    rst       = 1'b0;
    unit_done = '0;
    repeat (2) @(posedge clk);

    e = '{2'b00, '0, '0, '0, '0};
    sb.push_back(e);

    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      rst       = tbl[r].rst;
      unit_done = tbl[r].done;
      #1;
      tg = $sformatf("row%0d", r);

      ea = '0;
      if (tbl[r].rst && tbl[r].p0 >= 0) ea = ea | (4'd1 << tbl[r].p0);
      if (tbl[r].rst && tbl[r].p1 >= 0) ea = ea | (4'd1 << tbl[r].p1);
      chk({tg, " ack"}, 64'(unit_ack), 64'(ea));

      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s scoreboard: got empty queue, expected entry", tg);
      end else begin
        x = sb.pop_front();
        x.v = x.v & {2{tbl[r].rst}};
        chk({tg, " wb_valid"}, 64'(wb_valid), 64'(x.v));
        if (x.v[0]) begin
          chk({tg, " wb_id0"}, 64'(wb_id[IW-1:0]), 64'(x.id0));
          chk({tg, " wb_data0"}, wb_data[DW-1:0], x.d0);
        end
        if (x.v[1]) begin
          chk({tg, " wb_id1"}, 64'(wb_id[2*IW-1:IW]), 64'(x.id1));
          chk({tg, " wb_data1"}, wb_data[2*DW-1:DW], x.d1);
        end
      end

`ifdef FP_WB_ARB_PERF_EN
      chk({tg, " perf"}, 64'(perf_conflicts), 64'(perf_m));
`else
      chk({tg, " perf"}, 64'(perf_conflicts), 64'd0);
`endif

      e.v   = {tbl[r].rst && tbl[r].p1 >= 0,
               tbl[r].rst && tbl[r].p0 >= 0};
      e.id0 = (tbl[r].p0 >= 0) ? uid(tbl[r].p0) : '0;
      e.id1 = (tbl[r].p1 >= 0) ? uid(tbl[r].p1) : '0;
      e.d0  = (tbl[r].p0 >= 0) ? urd(tbl[r].p0) : '0;
      e.d1  = (tbl[r].p1 >= 0) ? urd(tbl[r].p1) : '0;
      sb.push_back(e);

      if (!tbl[r].rst)                  perf_m = 0;
      else if (popc(tbl[r].done) > 2)   perf_m = perf_m + 1;
    end

    // Long saturated load drives the conflict counter to its ceiling.
    sb.delete();
    @(negedge clk);
    rst       = 1'b1;
    unit_done = 4'b1111;
    repeat (65540) @(negedge clk);
    #1;
    chk("sat ack", 64'(unit_ack), 64'(4'b0011));
    chk("sat wb_valid", 64'(wb_valid), 64'(2'b11));
`ifdef FP_WB_ARB_PERF_EN
    chk("sat perf", 64'(perf_conflicts), 64'hFFFF);
`else
    chk("sat perf", 64'(perf_conflicts), 64'd0);
`endif

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst ack", 64'(unit_ack), 64'd0);
    chk("rst wb_valid", 64'(wb_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("rst perf", 64'(perf_conflicts), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
